// File: rtl/tcam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tcam_pkg
// Purpose  : Shared constants, helper function and types for the TCAM
//            match-resolver stage.
// Revision : 1.0 - initial release
// ============================================================================
package tcam_pkg;

    localparam int TCAM_RULES = 8;
    localparam int TCAM_IDX_W = 3;
    localparam int TCAM_TAG_W = 8;

    // Ceiling log2, used to size rule indices from the rule count.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    typedef logic [TCAM_RULES-1:0] match_vec_t;

endpackage
`default_nettype wire

// File: rtl/tcam_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : tcam_prio_enc
// Purpose  : Combinational priority encoder for a TCAM match vector.
//            Rule 0 sits on the MSB and has the highest priority; the index
//            returned is WIDTH-1 minus the position of the highest set bit.
//            Index is 0 when nothing matched.
// Revision : 1.0 - initial release
// ============================================================================
module tcam_prio_enc
    import tcam_pkg::*;
#(
    parameter int WIDTH = TCAM_RULES,
    parameter int IDX_W = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] match_vec,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan LSB to MSB so the highest set bit (lowest rule number) wins last.
    always_comb begin
        hit = |match_vec;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (match_vec[i]) begin
                idx = IDX_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcam_match_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tcam_match_resolver
// Purpose  : Resolves the highest-priority hit of one TCAM lookup, returns
//            {hit, index, tag} through a one-deep valid/ready register and
//            keeps saturating lookup / miss counters.
//            Optional macro TCAM_MULTIHIT_EN adds out_multi / out_nmatch.
// Revision : 1.0 - initial release
// ============================================================================
module tcam_match_resolver
    import tcam_pkg::*;
#(
    parameter int WIDTH = TCAM_RULES,
    parameter int IDX_W = clog2(WIDTH),
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      match_vec,
    input  logic [TCAM_TAG_W-1:0] in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_hit,
    output logic [IDX_W-1:0]      out_idx,
    output logic [TCAM_TAG_W-1:0] out_tag,
    input  logic                  clr_stats,
    output logic [CNT_W-1:0]      lookup_cnt,
`ifdef TCAM_MULTIHIT_EN
    output logic                  out_multi,
    output logic [IDX_W:0]        out_nmatch,
`endif
    output logic [CNT_W-1:0]      miss_cnt
);

    logic             w_accept;
    logic             w_enc_hit;
    logic [IDX_W-1:0] w_enc_idx;

    // The single output slot can take new data when empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    tcam_prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .match_vec (match_vec),
        .hit       (w_enc_hit),
        .idx       (w_enc_idx)
    );

    // Output valid flag: set on accept, cleared by a pop with no new accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Result register: loaded only on accept, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hit <= 1'b0;
            out_idx <= '0;
            out_tag <= '0;
        end else if (w_accept) begin
            out_hit <= w_enc_hit;
            out_idx <= w_enc_idx;
            out_tag <= in_tag;
        end
    end

    // Saturating statistics; a clear wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt <= '0;
            miss_cnt   <= '0;
        end else if (clr_stats) begin
            lookup_cnt <= '0;
            miss_cnt   <= '0;
        end else if (w_accept) begin
            if (lookup_cnt != {CNT_W{1'b1}}) begin
                lookup_cnt <= lookup_cnt + CNT_W'(1);
            end
            if (!w_enc_hit && (miss_cnt != {CNT_W{1'b1}})) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end

`ifdef TCAM_MULTIHIT_EN
    logic [IDX_W:0] w_popcnt;

    // Population count of the incoming match vector.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_popcnt = w_popcnt + (IDX_W+1)'(match_vec[i]);
        end
    end

    // Multi-hit results share the load/hold behaviour of out_idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_multi  <= 1'b0;
            out_nmatch <= '0;
        end else if (w_accept) begin
            out_multi  <= (w_popcnt >= (IDX_W+1)'(2));
            out_nmatch <= w_popcnt;
        end
    end
`endif

endmodule
`default_nettype wire
